bf16_vec_div_seq: RTL and testbench

BF16_VEC_DIV_SEQ -- requirements
Module: bf16_vec_div_seq

---
 rtl/bf16_pkg.sv | 12 +
 rtl/bf16_div_lane.sv | 140 ++++++++++++++
 rtl/bf16_vec_div_seq.sv | 87 ++++++++
 tb/tb_bf16_vec_div_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf16_pkg.sv
// Shared constants and FSM state type for the BFloat16 vector divider.
package bf16_pkg;

  localparam int unsigned BIAS     = 127;
  localparam logic [15:0] QNAN     = 16'h7FC0;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned FRAC_W   = 7;
  localparam int unsigned DIV_ITER = 10;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

endpackage

// File: rtl/bf16_div_lane.sv
// One BFloat16 divider lane: operand capture, restoring divide step, normalise,
// round-to-nearest-even and special-case resolution.
module bf16_div_lane
  import bf16_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        finish_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] q_o,
  output logic        dz_o,
  output logic        nv_o
);

  localparam logic [EXP_W-1:0] ExpMax = '1;

  logic [15:0]         a_q, b_q;
  logic [FRAC_W+1:0]   rem_q, rem_d;
  logic [DIV_ITER-1:0] quot_q, quot_d;
  logic [15:0]         res_q, res_d;
  logic                dz_q, dz_d, nv_q, nv_d;

  logic [EXP_W-1:0]    ea, eb;
  logic                a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign;
  logic [FRAC_W:0]     dvs;
  logic                ge;
  logic [FRAC_W+1:0]   diff;
  logic [FRAC_W-1:0]   frac;
  logic                guard, sticky, rnd;
  logic [FRAC_W:0]     frac_r;
  logic signed [10:0]  exp_s;
  logic [15:0]         norm;

  assign ea   = a_q[14:7];
  assign eb   = b_q[14:7];
  assign sign = a_q[15] ^ b_q[15];

  // A zero exponent field covers both zero and subnormals, which flushes the latter.
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == ExpMax) && (a_q[FRAC_W-1:0] == '0);
  assign b_inf  = (eb == ExpMax) && (b_q[FRAC_W-1:0] == '0);
  assign a_nan  = (ea == ExpMax) && (a_q[FRAC_W-1:0] != '0);
  assign b_nan  = (eb == ExpMax) && (b_q[FRAC_W-1:0] != '0);
  assign dvs    = {1'b1, b_q[FRAC_W-1:0]};

  // Remainder stays below twice the divisor, so 9 bits never overflow.
  always_comb begin
    rem_d  = rem_q;
    quot_d = quot_q;
    ge     = 1'b0;
    diff   = rem_q;
    if (load_i) begin
      rem_d  = {2'b01, a_i[FRAC_W-1:0]};
      quot_d = '0;
    end else if (step_i) begin
      ge     = (rem_q >= {1'b0, dvs});
      diff   = ge ? (rem_q - {1'b0, dvs}) : rem_q;
      rem_d  = {diff[FRAC_W:0], 1'b0};
      quot_d = {quot_q[DIV_ITER-2:0], ge};
    end
  end

  always_comb begin
    exp_s = $signed({3'b000, ea}) - $signed({3'b000, eb}) + $signed(11'(BIAS));
    if (quot_d[DIV_ITER-1]) begin
      frac   = quot_d[8:2];
      guard  = quot_d[1];
      sticky = quot_d[0] | (|rem_d);
    end else begin
      frac   = quot_d[7:1];
      guard  = quot_d[0];
      sticky = |rem_d;
      exp_s  = exp_s - 11'sd1;
    end
    rnd    = guard & (sticky | frac[0]);
    frac_r = {1'b0, frac} + {{FRAC_W{1'b0}}, rnd};
    if (frac_r[FRAC_W]) exp_s = exp_s + 11'sd1;
    if (exp_s >= 11'sd255) begin
      norm = {sign, ExpMax, {FRAC_W{1'b0}}};
    end else if (exp_s <= 11'sd0) begin
      norm = {sign, 15'd0};
    end else begin
      norm = {sign, exp_s[EXP_W-1:0], frac_r[FRAC_W-1:0]};
    end
  end

  always_comb begin
    res_d = res_q;
    dz_d  = dz_q;
    nv_d  = nv_q;
    if (finish_i) begin
      dz_d = 1'b0;
      nv_d = 1'b0;
      if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
        res_d = QNAN;
        nv_d  = 1'b1;
      end else if (b_zero & ~a_inf) begin
        res_d = {sign, ExpMax, {FRAC_W{1'b0}}};
        dz_d  = 1'b1;
      end else if (a_inf) begin
        res_d = {sign, ExpMax, {FRAC_W{1'b0}}};
      end else if (a_zero | b_inf) begin
        res_d = {sign, 15'd0};
      end else begin
        res_d = norm;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q    <= '0;
      b_q    <= '0;
      rem_q  <= '0;
      quot_q <= '0;
      res_q  <= '0;
      dz_q   <= 1'b0;
      nv_q   <= 1'b0;
    end else begin
      if (load_i) begin
        a_q <= a_i;
        b_q <= b_i;
      end
      rem_q  <= rem_d;
      quot_q <= quot_d;
      res_q  <= res_d;
      dz_q   <= dz_d;
      nv_q   <= nv_d;
    end
  end

  assign q_o  = res_q;
  assign dz_o = dz_q;
  assign nv_o = nv_q;

endmodule

// File: rtl/bf16_vec_div_seq.sv
// N-lane sequential BFloat16 divider: shared handshake FSM and iteration counter
// driving N independent lane datapaths.
module bf16_vec_div_seq
  import bf16_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [16*N-1:0] a,
  input  logic [16*N-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [16*N-1:0] q,
  output logic [N-1:0]    dz,
  output logic [N-1:0]    nv
);

  localparam int unsigned     CntW     = $clog2(DIV_ITER);
  localparam logic [CntW-1:0] LastIter = CntW'(DIV_ITER - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            load, step, finish;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIter) begin
          finish  = 1'b1;
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    bf16_div_lane u_lane (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .load_i   (load),
      .step_i   (step),
      .finish_i (finish),
      .a_i      (a[16*i +: 16]),
      .b_i      (b[16*i +: 16]),
      .q_o      (q[16*i +: 16]),
      .dz_o     (dz[i]),
      .nv_o     (nv[i])
    );
  end

endmodule

// File: tb/tb_bf16_vec_div_seq.sv
// Randomised and directed bench for bf16_vec_div_seq with an exact-arithmetic
// BFloat16 division model and a per-cycle scoreboard.
module tb_bf16_vec_div_seq;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] q;
  logic [N-1:0] dz, nv;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit seen = 1'b0;

  typedef struct {
    logic [W-1:0] q;
    logic [N-1:0] dz;
    logic [N-1:0] nv;
    int           acc;
  } exp_t;
  exp_t exp_q[$];

  bf16_vec_div_seq #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .dz        (dz),
    .nv        (nv)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required earlier end", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Exact quotient with true round-to-nearest-even; returns {nv, dz, q}.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y);
    int ea, eb, e;
    int unsigned ma, mb, num, sig, r;
    logic s;
    bit xz, yz, xi, yi, xn, yn;
    s  = x[15] ^ y[15];
    ea = int'(x[14:7]);
    eb = int'(y[14:7]);
    xz = (ea == 0);
    yz = (eb == 0);
    xi = (ea == 255) && (x[6:0] == 7'd0);
    yi = (eb == 255) && (y[6:0] == 7'd0);
    xn = (ea == 255) && (x[6:0] != 7'd0);
    yn = (eb == 255) && (y[6:0] != 7'd0);
    if (xn || yn || (xz && yz) || (xi && yi)) return {2'b10, 16'h7FC0};
    if (yz && !xi) return {2'b01, s, 15'h7F80};
    if (xi) return {2'b00, s, 15'h7F80};
    if (xz || yi) return {2'b00, s, 15'h0000};
    ma = 128 + int'(x[6:0]);
    mb = 128 + int'(y[6:0]);
    e  = ea - eb + 127;
    if (ma < mb) begin
      num = ma * 256;
      e   = e - 1;
    end else begin
      num = ma * 128;
    end
    sig = num / mb;
    r   = num % mb;
    if ((2 * r > mb) || ((2 * r == mb) && sig[0])) sig = sig + 1;
    if (sig == 256) begin
      sig = 128;
      e   = e + 1;
    end
    if (e >= 255) return {2'b00, s, 15'h7F80};
    if (e <= 0) return {2'b00, s, 15'h0000};
    return {2'b00, s, 8'(e), 7'(sig)};
  endfunction

  function automatic exp_t expect_vec(input logic [W-1:0] av, input logic [W-1:0] bv,
                                      input int acc);
    exp_t e;
    logic [17:0] r;
    for (int i = 0; i < N; i++) begin
      r               = model(av[16*i +: 16], bv[16*i +: 16]);
      e.q[16*i +: 16] = r[15:0];
      e.dz[i]         = r[16];
      e.nv[i]         = r[17];
    end
    e.acc = acc;
    return e;
  endfunction

  function automatic logic [15:0] rand_bf16();
    logic [15:0] v;
    int k;
    k = $urandom_range(0, 11);
    v = 16'($urandom);
    case (k)
      0: v[14:7] = 8'h00;
      1: begin v[14:7] = 8'hFF; v[6:0] = 7'd0; end
      2: begin v[14:7] = 8'hFF; v[0] = 1'b1; end
      3: v[14:7] = 8'($urandom_range(240, 254));
      4: v[14:7] = 8'($urandom_range(1, 15));
      default: v[14:7] = 8'($urandom_range(110, 145));
    endcase
    return v;
  endfunction

  // Scoreboard: in_ready, latency and result checked every falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      seen = 1'b0;
    end else begin
      check("in_ready", 64'(in_ready), 64'(exp_q.size() == 0));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          if (!seen) check("latency", 64'(cyc - exp_q[0].acc), 64'd10);
          seen = 1'b1;
          check("q", 64'(q), 64'(exp_q[0].q));
          check("dz", 64'(dz), 64'(exp_q[0].dz));
          check("nv", 64'(nv), 64'(exp_q[0].nv));
          if (out_ready) begin
            void'(exp_q.pop_front());
            seen = 1'b0;
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(expect_vec(a, b, cyc + 1));
    end
  end

  task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int stall, input bit rnd);
    int k;
    bit hs;
    out_ready = 1'b0;
    k = 0;
    while (!out_valid && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("out_valid_wait", 64'(out_valid), 64'd1);
    if (!out_valid) return;
    repeat (stall) begin
      @(posedge clk);
      #1;
    end
    hs = 1'b0;
    k  = 0;
    while (!hs && k < 100) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      hs = out_valid && out_ready;
      @(posedge clk);
      #1;
      k++;
    end
    out_ready = 1'b0;
    check("handshake_wait", 64'(hs), 64'd1);
  endtask

  initial begin
    // Hand-computed values pinning the model.
    check("pin_neg15_div_10", 64'(model(16'hC170, 16'h4120)), 64'h0BFC0);
    check("pin_4_div_3", 64'(model(16'h4080, 16'h4040)), 64'h03FAB);
    check("pin_1_div_0", 64'(model(16'h3F80, 16'h0000)), 64'h17F80);
    check("pin_neg1_div_0", 64'(model(16'hBF80, 16'h0000)), 64'h1FF80);
    check("pin_0_div_0", 64'(model(16'h0000, 16'h0000)), 64'h27FC0);
    check("pin_inf_div_inf", 64'(model(16'h7F80, 16'h7F80)), 64'h27FC0);
    check("pin_inf_div_0", 64'(model(16'h7F80, 16'h0000)), 64'h07F80);
    check("pin_1_div_1", 64'(model(16'h3F80, 16'h3F80)), 64'h03F80);
    check("pin_overflow", 64'(model(16'h7F00, 16'h3E80)), 64'h07F80);
    check("pin_underflow", 64'(model(16'h0080, 16'h4700)), 64'h00000);
    check("pin_subnormal_flush", 64'(model(16'h0001, 16'h3F80)), 64'h00000);

    #3;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_q", 64'(q), 64'd0);
    check("reset_dz", 64'(dz), 64'd0);
    check("reset_nv", 64'(nv), 64'd0);
    #19;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    accept({4{16'hC170}}, {4{16'h4120}});
    drain(0, 1'b0);
    accept({4{16'h4080}}, {4{16'h4040}});
    drain(0, 1'b0);
    accept({16'h3F80, 16'h0000, 16'h7F80, 16'h3F80}, {16'h0000, 16'h0000, 16'h7F80, 16'h3F80});
    drain(0, 1'b0);
    accept({16'h7F00, 16'h0080, 16'h7F00, 16'h0080}, {16'h3E80, 16'h4700, 16'h3E80, 16'h4700});
    drain(0, 1'b0);

    // Consumer stalls for 5 cycles in DONE.
    accept({16'h4080, 16'hC170, 16'h3F80, 16'h4040}, {16'h4040, 16'h4120, 16'h4040, 16'h3F80});
    drain(5, 1'b0);

    // A new request during BUSY must be ignored.
    accept({4{16'h4120}}, {4{16'h4080}});
    repeat (2) @(posedge clk);
    #1;
    a        = {4{16'h3F80}};
    b        = {4{16'h4000}};
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain(0, 1'b0);

    // Reset pulsed in the fourth BUSY cycle.
    accept({4{16'h4080}}, {4{16'h4040}});
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midbusy_rst_in_ready", 64'(in_ready), 64'd1);
    check("midbusy_rst_out_valid", 64'(out_valid), 64'd0);
    check("midbusy_rst_q", 64'(q), 64'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    accept({4{16'hC170}}, {4{16'h4120}});
    drain(0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      logic [W-1:0] ra, rb;
      for (int i = 0; i < N; i++) begin
        ra[16*i +: 16] = rand_bf16();
        rb[16*i +: 16] = rand_bf16();
      end
      accept(ra, rb);
      drain(int'($urandom_range(0, 2)), 1'b1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty_at_end", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
